// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the data path.
// Grants one requester at a time, drives the memory handshake and returns one-cycle hits.
module mem_arbiter #(
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iren,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dread,
   input  logic [1:0]  dwrite,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   output logic        dfault,
   input  logic        halt,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_store,
   output logic [3:0]  mem_strb,
   input  logic [31:0] mem_load,
   input  logic        mem_ready
);

   typedef enum logic [2:0] {
      IDLE,
      IREQ,
      DREQ,
      IDONE,
      DDONE,
      HALTED
   } state_e;

   localparam logic [7:0] SMAX = 8'(STARVE_MAX);

   state_e      state_q;
   logic [7:0]  starve_q;
   logic        ihit_q, dhit_q, dfault_q;
   logic        mem_ren_q, mem_wen_q;
   logic [31:0] mem_addr_q, mem_store_q, iload_q, dload_q;
   logic [3:0]  mem_strb_q;

   logic        d_req, grant_i, misalign_d;
   logic [3:0]  strb_d;
   logic [31:0] store_d;
   logic [7:0]  starve_d;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^iaddr[1:0];

   always_comb begin
      d_req      = dread | (dwrite != 2'b00);
      grant_i    = iren & (~d_req | (starve_q == SMAX));
      starve_d   = (starve_q == SMAX) ? starve_q : starve_q + 8'd1;
      strb_d     = '0;
      store_d    = '0;
      misalign_d = 1'b0;
      case (dwrite)
         2'b01: begin
            strb_d  = 4'b0001 << daddr[1:0];
            store_d = {4{dstore[7:0]}};
         end
         2'b10: begin
            strb_d     = daddr[1] ? 4'b1100 : 4'b0011;
            store_d    = {2{dstore[15:0]}};
            misalign_d = daddr[0];
         end
         2'b11: begin
            strb_d     = 4'b1111;
            store_d    = dstore;
            misalign_d = (daddr[1:0] != 2'b00);
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         dfault_q    <= 1'b0;
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_store_q <= '0;
         mem_strb_q  <= '0;
         iload_q     <= '0;
         dload_q     <= '0;
      end else begin
         ihit_q   <= 1'b0;
         dhit_q   <= 1'b0;
         dfault_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (halt) begin
                  state_q <= HALTED;
               end else if (grant_i) begin
                  state_q     <= IREQ;
                  starve_q    <= '0;
                  mem_ren_q   <= 1'b1;
                  mem_addr_q  <= {iaddr[31:2], 2'b00};
                  mem_strb_q  <= '0;
                  mem_store_q <= '0;
               end else if (d_req) begin
                  // a data grant only counts toward starvation while fetch is waiting
                  starve_q   <= iren ? starve_d : '0;
                  mem_addr_q <= {daddr[31:2], 2'b00};
                  if (dwrite != 2'b00) begin
                     if (misalign_d) begin
                        state_q  <= DDONE;
                        dhit_q   <= 1'b1;
                        dfault_q <= 1'b1;
                     end else begin
                        state_q     <= DREQ;
                        mem_wen_q   <= 1'b1;
                        mem_strb_q  <= strb_d;
                        mem_store_q <= store_d;
                     end
                  end else begin
                     state_q     <= DREQ;
                     mem_ren_q   <= 1'b1;
                     mem_strb_q  <= '0;
                     mem_store_q <= '0;
                  end
               end
            end
            IREQ: begin
               if (mem_ready) begin
                  state_q   <= IDONE;
                  mem_ren_q <= 1'b0;
                  iload_q   <= mem_load;
                  ihit_q    <= 1'b1;
               end
            end
            DREQ: begin
               if (mem_ready) begin
                  if (mem_ren_q) dload_q <= mem_load;
                  state_q    <= DDONE;
                  mem_ren_q  <= 1'b0;
                  mem_wen_q  <= 1'b0;
                  mem_strb_q <= '0;
                  dhit_q     <= 1'b1;
               end
            end
            IDONE, DDONE: begin
               state_q <= halt ? HALTED : IDLE;
            end
            HALTED: begin
               mem_ren_q  <= 1'b0;
               mem_wen_q  <= 1'b0;
               mem_strb_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ihit      = ihit_q;
   assign iload     = iload_q;
   assign dhit      = dhit_q;
   assign dload     = dload_q;
   assign dfault    = dfault_q;
   assign mem_ren   = mem_ren_q;
   assign mem_wen   = mem_wen_q;
   assign mem_addr  = mem_addr_q;
   assign mem_store = mem_store_q;
   assign mem_strb  = mem_strb_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and request sequencer between instruction fetch and the data path of the RISC-V core. It accepts one instruction-read requester and one data requester, grants the shared memory port to one at a time, and drives the memory handshake. It returns a one-cycle hit with load data. Write byte strobes are generated from the control unit's 2-bit store size, and the arbiter parks itself permanently on halt.

## Interface
- STARVE_MAX, 8: consecutive data grants allowed while an instruction request waits; the next grant is forced to instruction. Range 1–255.

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- iren  in  1  instruction read request, held until ihit
- iaddr  in  32  instruction address
- ihit  out  1  one-cycle instruction completion pulse
- iload  out  32  instruction word, valid while ihit=1
- dread  in  1  data read request, held until dhit
- dwrite  in  2  store size: 00 none, 01 byte, 10 half, 11 word; held until dhit
- daddr  in  32  data byte address
- dstore  in  32  store data, right-aligned
- dhit  out  1  one-cycle data completion pulse
- dload  out  32  word read from memory, valid while dhit=1
- dfault  out  1  pulses with dhit on a misaligned store
- halt  in  1  core halt
- mem_ren  out  1  memory read strobe
- mem_wen  out  1  memory write strobe
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_store  out  32  lane-replicated store data
- mem_strb  out  4  byte write enables
- mem_load  in  32  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completes current access

## Operation
- FSM states: IDLE, IREQ, DREQ, IDONE, DDONE, HALTED.
- **IDLE transitions:**
  - halt=1 → HALTED.
  - Else a data request (dread or dwrite≠00) → DREQ, unless iren=1 and the starve count equals STARVE_MAX → IREQ.
  - Else iren → IREQ.
  - In all cases the request's address and store data are latched.
- **Starve counter:**
  - Increments on each DREQ grant made while iren=1.
  - Clears on each IREQ grant, and on any DREQ grant made while iren=0.
  - Saturates at STARVE_MAX.
- **IREQ:** mem_ren=1 with the latched address. When mem_ready=1, capture mem_load and go to IDONE.
- **DREQ:**
  - If dwrite≠00: mem_wen=1, and the store takes precedence over a simultaneous dread. Otherwise mem_ren=1.
  - When mem_ready=1: capture mem_load on reads, then go to DDONE.
- **IDONE / DDONE:**
  - Assert ihit or dhit for exactly one cycle, with iload/dload holding the captured word.
  - Next state: HALTED if halt=1, else IDLE.
  - Requesters must drop or change their request in the cycle after the hit, so the arbiter never re-grants a stale request.
- **Store lanes:**
  - Byte: mem_strb = 1<<daddr[1:0]; mem_store = {4{dstore[7:0]}}.
  - Half: mem_strb = daddr[1] ? 1100 : 0011; mem_store = {2{dstore[15:0]}}.
  - Word: mem_strb = 1111; mem_store = dstore.
- **Misaligned store** (half with daddr[0]=1, or word with daddr[1:0]≠00):
  - No memory access; mem_wen stays 0.
  - Go directly to DDONE with dfault=1.
- **Reads:** always full-word with mem_strb=0000. Byte/half extraction and sign extension belong to the datapath.
- **halt asserted mid-access:** the current access completes normally, including its hit pulse, then the arbiter enters HALTED.
- **HALTED:** all memory strobes are 0 and all requests are ignored. Exit is by nRST only.

## Timing
- All outputs are registered or decoded from state plus latched registers; there is no combinational path from inputs to outputs.
- Reset values: state=IDLE, starve count=0. All outputs are 0: ihit, dhit, dfault, mem_ren, mem_wen, mem_strb, mem_addr, mem_store, iload, dload.
- **Latency:**
  - Request sampled in IDLE at cycle 0.
  - Memory strobe asserted from cycle 1.
  - mem_ready first sampled high at cycle k≥1.
  - Hit asserted at cycle k+1.
  - Back in IDLE at cycle k+2.
  - Minimum 3 cycles per access.
- Misaligned store: request at cycle 0, dhit+dfault at cycle 1.
- The memory strobe, mem_addr, mem_store and mem_strb are stable for the entire IREQ/DREQ occupancy.
- The cycle after mem_ready is sampled high, the strobe is low.
- nRST low during any state aborts the access asynchronously: strobes drop immediately and no hit is issued. The memory model must tolerate the abandoned request.

## Test plan
- **Reset:** nRST=0 with iren=1, dread=1 → all outputs 0, no strobe; after release, the first strobe appears 1 cycle later.
- **Instruction fetch:** iren=1, iaddr=0x0000_0104, mem_ready=1 after 2 wait cycles, mem_load=0x0010_0093 → mem_ren with mem_addr 0x104 for 3 cycles; ihit one cycle later with iload=0x0010_0093.
- **Simultaneous requests:** iren=1 and dread=1 both in IDLE, daddr=0x200 → data granted first; the instruction is granted immediately after DDONE.
- **Byte store:** dwrite=01, daddr=0x0000_0302, dstore=0x0000_00AB → mem_wen, mem_addr=0x300, mem_strb=0100, mem_store=0xABABABAB.
- **Misaligned store:** word store at 0x0000_0306 → no mem_wen, dhit=dfault=1 at cycle 1.
- **Starvation and halt:**
  - STARVE_MAX=2, continuous data requests with iren held → grant order D, D, I, D, D, I.
  - halt asserted during DREQ → that dhit still issues, then HALTED; iren ignored thereafter until nRST.
